// File: rtl/debug_probe_pkg.sv
// Shared types for the debug-probe capture scheduler.
package debug_probe_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      DRAIN
   } sched_state_e;

   localparam int TS_W = 16;

endpackage

// File: rtl/debug_probe_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr, wrapping.
module debug_probe_rr_pick
   import debug_probe_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         winner,
   output logic [$clog2(NUM_REQ)-1:0] index,
   output logic                       any
);

   localparam int IDX_W = $clog2(NUM_REQ);

   // One extra bit so ptr + offset can exceed NUM_REQ before the wrap subtract.
   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] k;

   always_comb begin
      winner = '0;
      index  = '0;
      any    = 1'b0;
      sum    = '0;
      k      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr} + (IDX_W+1)'(i);
         if (sum >= (IDX_W+1)'(NUM_REQ)) begin
            sum = sum - (IDX_W+1)'(NUM_REQ);
         end
         k = sum[IDX_W-1:0];
         if (!any && req[k]) begin
            any       = 1'b1;
            index     = k;
            winner[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/debug_probe_sched.sv
// Shared debug-probe capture buffer: round-robin grant, capture window, tagged drain.
// Optional DEBUG_PROBE_SCHED_TIMESTAMP_EN adds a per-window start timestamp on rd_ts_o.
//
// state   | meaning
// IDLE    | no owner; pick next requester from rr_ptr
// CAPTURE | grant held; write probe word of sel each cycle its request stays high
// DRAIN   | present captured samples on the read port until the last one is accepted
module debug_probe_sched
   import debug_probe_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 16,
   parameter int CAPT_LEN = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_i,
   input  logic [NUM_REQ*DATA_W-1:0]    probe_i,
   output logic [NUM_REQ-1:0]           gnt_o,
   output logic                         busy_o,
   output logic                         rd_valid_o,
   input  logic                         rd_ready_i,
   output logic [DATA_W-1:0]            rd_data_o,
   output logic [$clog2(NUM_REQ)-1:0]   rd_src_o,
`ifdef DEBUG_PROBE_SCHED_TIMESTAMP_EN
   output logic [TS_W-1:0]              rd_ts_o,
`endif
   output logic                         rd_last_o
);

   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int CNT_W  = $clog2(CAPT_LEN + 1);
   localparam int BUF_AW = $clog2(CAPT_LEN);

   sched_state_e      state, state_nxt;
   logic [NUM_REQ-1:0] gnt_q, pick_win;
   logic [IDX_W-1:0]   sel, rr_ptr, pick_idx, sel_inc;
   logic               pick_any;
   logic [CNT_W-1:0]   count, rd_ptr;
   logic [DATA_W-1:0]  cap_buf   [CAPT_LEN];
   logic [DATA_W-1:0]  probe_arr [NUM_REQ];
   logic               start_win, cap_we, rd_last, end_empty, drain_adv, drain_done;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_probe
      assign probe_arr[g] = probe_i[g*DATA_W +: DATA_W];
   end

   debug_probe_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req    (req_i),
      .ptr    (rr_ptr),
      .winner (pick_win),
      .index  (pick_idx),
      .any    (pick_any)
   );

   assign sel_inc = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
   assign rd_last = (rd_ptr == count - 1'b1);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      start_win  = 1'b0;
      cap_we     = 1'b0;
      end_empty  = 1'b0;
      drain_adv  = 1'b0;
      drain_done = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any) begin
               state_nxt = CAPTURE;
               start_win = 1'b1;
            end
         end
         CAPTURE: begin
            if (req_i[sel]) begin
               cap_we = 1'b1;
               if (count == CNT_W'(CAPT_LEN - 1)) state_nxt = DRAIN;
            end else if (count != '0) begin
               state_nxt = DRAIN;
            end else begin
               state_nxt = IDLE;
               end_empty = 1'b1;
            end
         end
         DRAIN: begin
            if (rd_ready_i) begin
               if (rd_last) begin
                  state_nxt  = IDLE;
                  drain_done = 1'b1;
               end else begin
                  drain_adv = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q  <= '0;
         sel    <= '0;
         rr_ptr <= '0;
         count  <= '0;
         rd_ptr <= '0;
      end else begin
         if (start_win) begin
            gnt_q <= pick_win;
            sel   <= pick_idx;
            count <= '0;
         end
         if (cap_we) count <= count + 1'b1;
         if (state == CAPTURE && state_nxt != CAPTURE) begin
            gnt_q  <= '0;
            rd_ptr <= '0;
         end
         if (drain_adv) rd_ptr <= rd_ptr + 1'b1;
         if (end_empty || drain_done) rr_ptr <= sel_inc;
      end
   end

   // Buffer contents need no reset: the read port is gated outside DRAIN.
   always_ff @(posedge clk) begin
      if (cap_we) cap_buf[count[BUF_AW-1:0]] <= probe_arr[sel];
   end

   assign gnt_o      = gnt_q;
   assign busy_o     = (state != IDLE);
   assign rd_valid_o = (state == DRAIN);
   assign rd_data_o  = rd_valid_o ? cap_buf[rd_ptr[BUF_AW-1:0]] : '0;
   assign rd_src_o   = rd_valid_o ? sel : '0;
   assign rd_last_o  = rd_valid_o & rd_last;

`ifdef DEBUG_PROBE_SCHED_TIMESTAMP_EN
   logic [TS_W-1:0] ts_cnt, ts_lat;

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_cnt <= '0;
         ts_lat <= '0;
      end else begin
         ts_cnt <= ts_cnt + 1'b1;
         if (cap_we && count == '0) ts_lat <= ts_cnt;
      end
   end

   assign rd_ts_o = ts_lat;
`endif

endmodule

// File: tb/tb_debug_probe_sched.sv
// Bench for debug_probe_sched: vector table, corner sequences, random run against a queue-based model.
module tb_debug_probe_sched;

   localparam int NUM_REQ  = 4;
   localparam int DATA_W   = 16;
   localparam int CAPT_LEN = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_i;
   logic [63:0] probe_i;
   logic [3:0]  gnt_o;
   logic        busy_o, rd_valid_o, rd_ready_i, rd_last_o;
   logic [15:0] rd_data_o;
   logic [1:0]  rd_src_o;
`ifdef DEBUG_PROBE_SCHED_TIMESTAMP_EN
   logic [15:0] rd_ts_o;
`endif

   debug_probe_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CAPT_LEN(CAPT_LEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req_i),
      .probe_i    (probe_i),
      .gnt_o      (gnt_o),
      .busy_o     (busy_o),
      .rd_valid_o (rd_valid_o),
      .rd_ready_i (rd_ready_i),
      .rd_data_o  (rd_data_o),
      .rd_src_o   (rd_src_o),
`ifdef DEBUG_PROBE_SCHED_TIMESTAMP_EN
      .rd_ts_o    (rd_ts_o),
`endif
      .rd_last_o  (rd_last_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: owner + phase flags + queue of captured words.
   int          m_owner;
   bit          m_cap, m_drn;
   int          m_rr;
   int          m_rd;
   logic [15:0] m_q[$];

   task automatic model_reset();
      m_owner = 0; m_cap = 0; m_drn = 0; m_rr = 0; m_rd = 0;
      m_q.delete();
   endtask

   task automatic check_model();
      logic [3:0]  eg;
      logic [15:0] ed;
      logic [1:0]  es;
      logic        el;
      eg = m_cap ? 4'(1 << m_owner) : 4'b0;
      ed = m_drn ? m_q[m_rd] : 16'h0;
      es = m_drn ? 2'(m_owner) : 2'd0;
      el = m_drn && (m_rd == m_q.size() - 1);
      chk($sformatf("model_outputs@%0t", $time),
          {gnt_o, busy_o, rd_valid_o, rd_data_o, rd_src_o, rd_last_o},
          {eg, m_cap || m_drn, m_drn, ed, es, el});
   endtask

   task automatic model_step();
      bit found;
      found = 0;
      if (!m_cap && !m_drn) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            int k;
            k = (m_rr + i) % NUM_REQ;
            if (!found && req_i[k]) begin
               found = 1; m_owner = k; m_cap = 1; m_q.delete();
            end
         end
      end else if (m_cap) begin
         if (req_i[m_owner]) begin
            m_q.push_back(probe_i[m_owner*DATA_W +: DATA_W]);
            if (m_q.size() == CAPT_LEN) begin
               m_cap = 0; m_drn = 1; m_rd = 0;
            end
         end else begin
            m_cap = 0;
            if (m_q.size() > 0) begin
               m_drn = 1; m_rd = 0;
            end else begin
               m_rr = (m_owner + 1) % NUM_REQ;
            end
         end
      end else if (rd_ready_i) begin
         if (m_rd == m_q.size() - 1) begin
            m_drn = 0; m_rr = (m_owner + 1) % NUM_REQ;
         end else begin
            m_rd++;
         end
      end
   endtask

   // Called at posedge+1: apply inputs, compare, advance model, move to next posedge+1.
   task automatic cycle(input logic [3:0] req, input logic [63:0] probe, input logic ready);
      req_i = req; probe_i = probe; rd_ready_i = ready;
      #3;
      check_model();
      model_step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_i = '0; rd_ready_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   function automatic logic [63:0] rnd_probe();
      return {$urandom(), $urandom()};
   endfunction

   typedef struct {
      logic [3:0]  req;
      logic [15:0] p;
      logic        ready;
      logic [3:0]  e_gnt;
      logic        e_valid;
      logic [15:0] e_data;
      logic [1:0]  e_src;
      logic        e_last;
   } vec_t;

   vec_t tbl[19];

   initial begin
      int beats, last_at, n_gr;
      int grants[5];
      logic [3:0]  prev_gnt;
      logic        prev_valid, prev_ready, rdy;
      logic [18:0] snap;
      logic [3:0]  rq;

      rst = 1'b1; req_i = '0; probe_i = '0; rd_ready_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      chk("reset_outputs", {gnt_o, busy_o, rd_valid_o, rd_data_o, rd_src_o, rd_last_o}, '0);

      // Single requester, full window, then rr_ptr=2 shown by the next pick.
      for (int r = 0; r < 19; r++) begin
         tbl[r] = '{req: 4'b0010, p: 16'h0, ready: 1'b1, e_gnt: 4'b0,
                    e_valid: 1'b0, e_data: 16'h0, e_src: 2'd0, e_last: 1'b0};
         if (r >= 1 && r <= 8) begin
            tbl[r].p = 16'(r); tbl[r].e_gnt = 4'b0010;
         end
         if (r >= 9 && r <= 16) begin
            tbl[r].e_valid = 1'b1; tbl[r].e_data = 16'(r - 8);
            tbl[r].e_src = 2'd1; tbl[r].e_last = (r == 16);
         end
         if (r >= 16) tbl[r].req = 4'b0110;
         if (r == 18) tbl[r].e_gnt = 4'b0100;
      end
      for (int r = 0; r < 19; r++) begin
         req_i = tbl[r].req;
         probe_i = {16'h4444, 16'h3333, tbl[r].p, 16'h1111};
         rd_ready_i = tbl[r].ready;
         #3;
         chk($sformatf("tbl_row%0d", r),
             {gnt_o, busy_o, rd_valid_o, rd_data_o, rd_src_o, rd_last_o},
             {tbl[r].e_gnt, (tbl[r].e_gnt != 4'b0) || tbl[r].e_valid, tbl[r].e_valid,
              tbl[r].e_data, tbl[r].e_src, tbl[r].e_last});
         @(posedge clk); #1;
      end

      // Early drop after 3 samples.
      do_reset();
      for (int i = 0; i < 4; i++) cycle(4'b0100, rnd_probe(), 1'b1);
      cycle(4'b0000, rnd_probe(), 1'b1);
      beats = 0; last_at = -1;
      for (int i = 0; i < 10; i++) begin
         if (rd_valid_o) begin
            beats++;
            if (rd_last_o) last_at = beats;
         end
         cycle(4'b0000, rnd_probe(), 1'b1);
      end
      chk("drop_beats", 64'(beats), 64'd3);
      chk("drop_last_pos", 64'(last_at), 64'd3);

      // Drop in the first granted cycle: no drain, rr moves past the owner.
      cycle(4'b0001, rnd_probe(), 1'b1);
      cycle(4'b0000, rnd_probe(), 1'b1);
      chk("drop0_idle", {busy_o, rd_valid_o}, 2'b00);
      cycle(4'b0011, rnd_probe(), 1'b1);
      chk("drop0_rr", gnt_o, 4'b0010);

      // Backpressure with ready pattern 1,0,0,...
      do_reset();
      prev_valid = 0; prev_ready = 1; beats = 0; snap = '0;
      for (int i = 0; i < 40; i++) begin
         rdy = (i % 3 == 0);
         if (prev_valid && !prev_ready)
            chk("stall_hold", {rd_valid_o, rd_data_o, rd_src_o}, snap);
         if (rd_valid_o && rdy) beats++;
         snap = {rd_valid_o, rd_data_o, rd_src_o};
         prev_valid = rd_valid_o; prev_ready = rdy;
         cycle((i < 9) ? 4'b1000 : 4'b0000, rnd_probe(), rdy);
      end
      chk("bp_beats", 64'(beats), 64'd8);

      // Reset mid-drain after 2 of 8 beats.
      do_reset();
      for (int i = 0; i < 11; i++) cycle(4'b0100, rnd_probe(), 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_middrain", {gnt_o, busy_o, rd_valid_o, rd_data_o, rd_src_o, rd_last_o}, '0);
      rst = 1'b0;
      model_reset();
      cycle(4'b1111, rnd_probe(), 1'b1);
      chk("rst_regrant", gnt_o, 4'b0001);

      // Fairness with all requests held.
      do_reset();
      n_gr = 0; prev_gnt = '0;
      for (int i = 0; i < 150 && n_gr < 5; i++) begin
         cycle(4'b1111, rnd_probe(), 1'b1);
         if (gnt_o != 4'b0 && prev_gnt == 4'b0) begin
            for (int b = 0; b < 4; b++) if (gnt_o[b]) grants[n_gr] = b;
            n_gr++;
         end
         prev_gnt = gnt_o;
      end
      for (int k = 0; k < 5; k++)
         chk($sformatf("fair_%0d", k), 64'((k < n_gr) ? grants[k] : 99), 64'(k % 4));

      // Random traffic against the model.
      do_reset();
      rq = '0;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
         if ($urandom_range(0, 599) == 0) do_reset();
         else cycle(rq, rnd_probe(), $urandom_range(0, 3) != 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
